lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit sitting directly upstream of the byte-addressed data memory (mem: clk, wen, addr, wdata, rdata).
//  Accepts one RV32 load/store request at a time from the pipeline.
//  Loads: extracts the byte, halfword or word and sign/zero-extends it.
//  Stores: sub-word stores use read-modify-write, because the memory always writes 4 bytes at addr..addr+3.
//  Rejects out-of-range accesses with a fault response.
// PARAMETERS
//  MEM_BYTES  32  size of the data memory in bytes; legal addr range 0..MEM_BYTES-4
//  ADDR_W     32  request/memory address width
// PORTS
//  clk          in   1       single clock, all state updates on posedge
//  rst_n        in   1       synchronous, active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       high only in IDLE; transfer when req_valid && req_ready at posedge
//  req_we       in   1       1 = store, 0 = load
//  req_funct3   in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, right-aligned
//  resp_valid   out  1       one-cycle pulse; no backpressure, consumer must take it
//  resp_rdata   out  32      extended load data (0 for stores and faults)
//  resp_fault   out  1       qualified by resp_valid; illegal funct3 or out-of-range addr
//  mem_wen      out  1       to memory wen
//  mem_addr     out  ADDR_W  to memory addr
//  mem_wdata    out  32      to memory wdata
//  mem_rdata    in   32      from memory rdata (combinational read)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - state=IDLE; resp_valid=0, resp_rdata=0, resp_fault=0.
//    - All latched request fields are cleared to 0.
//    - mem_wen is ANDed with rst_n, so no write commits in a reset cycle, even mid-RMW.
//  - On accept, latch we, funct3, addr and wdata. mem_addr = latched addr in every non-IDLE state.
//  - Check on accept:
//    - fault if addr > MEM_BYTES-4 (the memory touches 4 bytes for every access);
//    - fault if funct3 is illegal (store with 1xx, or 011/110/111).
//    - Fault -> RESP directly, with no memory access.
//  - FSM IDLE -> {LOAD | WRITE | RMW_RD | RESP}:
//    - LOAD: mem_wen=0. At the edge, register extract(mem_rdata) into resp_rdata. -> RESP.
//    - WRITE (SW): mem_wen=1, mem_wdata=req_wdata. -> RESP.
//    - RMW_RD (SB/SH): capture mem_rdata into merge_q. -> RMW_WR.
//    - RMW_WR: mem_wen=1. mem_wdata = merge_q with byte[7:0] (SB) or bytes[15:0] (SH) replaced from req_wdata. -> RESP.
//    - RESP: resp_valid=1 for exactly one cycle. -> IDLE.
//  - Latency from accept edge to resp_valid: LW/LH/LB/SW = 2 cycles; SB/SH = 3 cycles; fault = 1 cycle.
//  - Throughput: one request per (latency+1) cycles. req_ready=0 from accept until back in IDLE.
//  - Extraction (little-endian, aligned to addr):
//    - B  = sext(rdata[7:0]);  BU = zext(rdata[7:0]).
//    - H  = sext(rdata[15:0]); HU = zext(rdata[15:0]).
//    - W  = rdata.
//  - Boundary cases:
//    - addr=MEM_BYTES-4 is legal; addr=MEM_BYTES-3 faults.
//    - Address arithmetic is ADDR_W wide; no wrap-around to 0 is ever issued.
//    - req_valid held while not ready: ignored until IDLE, and the request must stay stable.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN:
//   - Defined: H/HU/SH with addr[0]!=0 and W/SW with addr[1:0]!=0 fault, with no memory access.
//   - Undefined: misaligned accesses proceed as normal, since the memory is byte-granular.
// STRUCTURE
//  - Package lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state encoding (3-bit).
//  - Sub-module lsu_align (combinational): load extract/extend plus store merge (merge_q, wdata, size) -> word.
//  - The top level holds only the FSM, the request latches and the range check.
// TESTING
//  1. Memory preloaded with 0x80FF7F01 at addr 4:
//     - LB @4 -> 0x00000001; LH @4 -> 0x00007F01;
//     - LB @7 -> 0xFFFFFF80; LBU @7 -> 0x00000080.
//     - Each has resp_valid 2 cycles after accept.
//  2. SW 0xDEADBEEF @8, then LW @8 -> 0xDEADBEEF.
//     - mem_wen high exactly 1 cycle; resp_fault=0.
//  3. Word 0x11223344 @12, then SB 0xAA @12 -> LW @12 = 0x112233AA; SH 0xBBCC @12 -> 0x1122BBCC.
//     - resp_valid 3 cycles after accept.
//  4. Range check:
//     - LW @28 returns the data.
//     - LW @29 and SB @31 -> resp_fault=1 after 1 cycle, with mem_wen never high.
//     - funct3=011 -> fault.
//  5. Reset mid-operation: assert rst_n=0 during RMW_WR of SB @0.
//     - mem word @0 is unchanged; state returns to IDLE with req_ready=1 after release; no resp_valid.
//  6. With LSU_MISALIGN_TRAP_EN: LW @2 -> fault. Without it: LW @2 returns bytes 2..5.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 encodings, FSM states
// and the funct3 legality helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StWrite = 3'd2,
      StRmwRd = 3'd3,
      StRmwWr = 3'd4,
      StResp  = 3'd5
   } lsu_state_e;

   // Stores only accept B/H/W; loads additionally accept BU/HU.
   function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the load/store unit: little-endian load extract with
// sign/zero extension, and sub-word store merge into a previously read word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] rdata,
   input  logic [31:0] merge,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   always_comb begin
      load_data = rdata;
      case (funct3)
         F3_B:    load_data = {{24{rdata[7]}}, rdata[7:0]};
         F3_BU:   load_data = {24'd0, rdata[7:0]};
         F3_H:    load_data = {{16{rdata[15]}}, rdata[15:0]};
         F3_HU:   load_data = {16'd0, rdata[15:0]};
         default: load_data = rdata;
      endcase
   end

   always_comb begin
      store_data = wdata;
      case (funct3)
         F3_B:    store_data = {merge[31:8], wdata[7:0]};
         F3_H:    store_data = {merge[31:16], wdata[15:0]};
         default: store_data = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a byte-addressed, 4-byte-wide-write data memory.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/HU/SH and W/SW into faults.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 32,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   // Every access touches addr..addr+3, so the last legal address is MEM_BYTES-4.
   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

   lsu_state_e        state_q, state_d;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       merge_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_fault_q;

   logic              accept;
   logic              misalign;
   logic              req_fault;
   logic              wen_raw;
   logic [31:0]       load_data;
   logic [31:0]       store_data;

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      case (req_funct3)
         F3_H, F3_HU: misalign = req_addr[0];
         F3_W:        misalign = |req_addr[1:0];
         default:     misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   assign accept    = req_valid && (state_q == StIdle);
   assign req_fault = (req_addr > MAX_ADDR) || !funct3_legal(req_we, req_funct3) || misalign;

   always_comb begin
      state_d = state_q;
      wen_raw = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (req_fault)             state_d = StResp;
               else if (!req_we)          state_d = StLoad;
               else if (req_funct3 == F3_W) state_d = StWrite;
               else                       state_d = StRmwRd;
            end
         end
         StLoad:  state_d = StResp;
         StWrite: begin
            wen_raw = 1'b1;
            state_d = StResp;
         end
         StRmwRd: state_d = StRmwWr;
         StRmwWr: begin
            wen_raw = 1'b1;
            state_d = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         we_q         <= 1'b0;
         funct3_q     <= 3'd0;
         addr_q       <= '0;
         wdata_q      <= '0;
         merge_q      <= '0;
         resp_rdata_q <= '0;
         resp_fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q         <= req_we;
            funct3_q     <= req_funct3;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            resp_fault_q <= req_fault;
         end
         if (state_q == StLoad && !we_q) resp_rdata_q <= load_data;
         if (state_q == StRmwRd)         merge_q      <= mem_rdata;
      end
   end

   lsu_align u_align (
      .funct3     (funct3_q),
      .rdata      (mem_rdata),
      .merge      (merge_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = resp_rdata_q;
   assign resp_fault = resp_fault_q;
   // Gating with rst_n keeps a reset that lands mid-RMW from committing a write.
   assign mem_wen    = wen_raw & rst_n;
   assign mem_addr   = addr_q;
   assign mem_wdata  = store_data;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a 32-byte behavioural memory.
// Honours LSU_MISALIGN_TRAP_EN when checking the misaligned word load.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          lat;
      int          wens;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic [7:0] mem [0:31];

   always #5 clk = ~clk;

   lsu_mem_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always_comb begin
      mem_rdata = '0;
      if (mem_addr <= 32'd28)
         mem_rdata = {mem[5'(mem_addr[4:0] + 5'd3)], mem[5'(mem_addr[4:0] + 5'd2)],
                      mem[5'(mem_addr[4:0] + 5'd1)], mem[mem_addr[4:0]]};
   end

   always @(posedge clk) begin
      if (mem_wen && mem_addr <= 32'd28) begin
         mem[mem_addr[4:0]]              <= mem_wdata[7:0];
         mem[5'(mem_addr[4:0] + 5'd1)]   <= mem_wdata[15:8];
         mem[5'(mem_addr[4:0] + 5'd2)]   <= mem_wdata[23:16];
         mem[5'(mem_addr[4:0] + 5'd3)]   <= mem_wdata[31:24];
      end
   end

   function automatic logic [31:0] word_at(input int a);
      return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request, push its expectation, then watch for the response.
   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ef, input int el, input int ew);
      exp_t e;
      int   cyc;
      int   wens;
      bit   seen;
      @(negedge clk);
      check_eq({tag, ".ready"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      exp_q.push_back('{rdata: er, fault: ef, lat: el, wens: ew});
      #1;
      req_valid = 1'b0;
      cyc  = 0;
      wens = 0;
      seen = 1'b0;
      while (!seen && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (mem_wen) wens++;
         if (resp_valid) begin
            seen = 1'b1;
            e = exp_q.pop_front();
            check_eq({tag, ".rdata"}, resp_rdata, e.rdata);
            check_eq({tag, ".fault"}, 32'(resp_fault), 32'(e.fault));
            check_eq({tag, ".lat"}, 32'(cyc), 32'(e.lat));
            check_eq({tag, ".wen"}, 32'(wens), 32'(e.wens));
         end
      end
      if (!seen) begin
         check_eq({tag, ".timeout"}, 32'(seen), 32'd1);
         void'(exp_q.pop_front());
      end
      @(negedge clk);
      check_eq({tag, ".pulse"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = '0;
      req_wdata  = '0;
      repeat (2) @(negedge clk);
      check_eq("rst.resp_valid", 32'(resp_valid), 32'd0);
      check_eq("rst.mem_wen", 32'(mem_wen), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst.ready", 32'(req_ready), 32'd1);
      check_eq("rst.rdata", resp_rdata, 32'd0);
      check_eq("rst.fault", 32'(resp_fault), 32'd0);

      // Preload and sub-word load extraction
      do_req("sw0",  1'b1, 3'b010, 32'd0, 32'h44332211, 32'h0, 1'b0, 2, 1);
      do_req("sw4",  1'b1, 3'b010, 32'd4, 32'h80FF7F01, 32'h0, 1'b0, 2, 1);
      do_req("lb4",  1'b0, 3'b000, 32'd4, 32'h0, 32'h00000001, 1'b0, 2, 0);
      do_req("lh4",  1'b0, 3'b001, 32'd4, 32'h0, 32'h00007F01, 1'b0, 2, 0);
      do_req("lb7",  1'b0, 3'b000, 32'd7, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0);
      do_req("lbu7", 1'b0, 3'b100, 32'd7, 32'h0, 32'h00000080, 1'b0, 2, 0);
      do_req("lh6",  1'b0, 3'b001, 32'd6, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0);
      do_req("lhu6", 1'b0, 3'b101, 32'd6, 32'h0, 32'h000080FF, 1'b0, 2, 0);

      // Word store and read-modify-write
      do_req("sw8",   1'b1, 3'b010, 32'd8,  32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
      do_req("lw8",   1'b0, 3'b010, 32'd8,  32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
      do_req("sw12",  1'b1, 3'b010, 32'd12, 32'h11223344, 32'h0, 1'b0, 2, 1);
      do_req("sb12",  1'b1, 3'b000, 32'd12, 32'h555555AA, 32'h0, 1'b0, 3, 1);
      do_req("lw12a", 1'b0, 3'b010, 32'd12, 32'h0, 32'h112233AA, 1'b0, 2, 0);
      do_req("sh12",  1'b1, 3'b001, 32'd12, 32'h1234BBCC, 32'h0, 1'b0, 3, 1);
      do_req("lw12b", 1'b0, 3'b010, 32'd12, 32'h0, 32'h1122BBCC, 1'b0, 2, 0);

      // Range and funct3 checks
      do_req("sw28",   1'b1, 3'b010, 32'd28, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1);
      do_req("lw28",   1'b0, 3'b010, 32'd28, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0);
      do_req("lw29",   1'b0, 3'b010, 32'd29, 32'h0, 32'h0, 1'b1, 1, 0);
      do_req("sb31",   1'b1, 3'b000, 32'd31, 32'h77, 32'h0, 1'b1, 1, 0);
      do_req("f3_011", 1'b0, 3'b011, 32'd0,  32'h0, 32'h0, 1'b1, 1, 0);
      do_req("sbu",    1'b1, 3'b100, 32'd0,  32'h66, 32'h0, 1'b1, 1, 0);
      do_req("lwtop",  1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1, 0);
      check_eq("sb31.mem28", word_at(28), 32'hCAFEF00D);

`ifdef LSU_MISALIGN_TRAP_EN
      do_req("lw2", 1'b0, 3'b010, 32'd2, 32'h0, 32'h0, 1'b1, 1, 0);
`else
      do_req("lw2", 1'b0, 3'b010, 32'd2, 32'h0, 32'h7F014433, 1'b0, 2, 0);
`endif

      // Reset landing in the write phase of an SB
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'd0;
      req_wdata  = 32'h99;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rmw.wen_pre", 32'(mem_wen), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rmw.wen_rst", 32'(mem_wen), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("rmw.mem0", word_at(0), 32'h44332211);
      check_eq("rmw.ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rmw.no_resp", 32'(resp_valid), 32'd0);
      end
      check_eq("rmw.mem0_after", word_at(0), 32'h44332211);
      check_eq("queue.empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

endmodule
